// File: rtl/alu_secuenciador_pkg.sv
// -----------------------------------------------------------------------------
// alu_secuenciador_pkg
// Shared definitions for the ALU command sequencer:
//   - ALU select codes (codes at or above OP_RESERVED_MIN are illegal)
//   - sequencer state encoding
//   - bit positions inside the 4-bit flag register {negativo, zero, cout, overflow}
//   - small helpers to classify op codes
// -----------------------------------------------------------------------------
package alu_secuenciador_pkg;

  localparam logic [3:0] OP_SUMA         = 4'd0;
  localparam logic [3:0] OP_RESTA        = 4'd1;
  localparam logic [3:0] OP_INC          = 4'd2;
  localparam logic [3:0] OP_DEC          = 4'd3;
  localparam logic [3:0] OP_AND          = 4'd4;
  localparam logic [3:0] OP_OR           = 4'd5;
  localparam logic [3:0] OP_NOT          = 4'd6;
  localparam logic [3:0] OP_XOR          = 4'd7;
  localparam logic [3:0] OP_SHL          = 4'd8;
  localparam logic [3:0] OP_SHR          = 4'd9;
  localparam logic [3:0] OP_RESERVED_MIN = 4'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EJECUTA = 2'd1,
    ESCRIBE = 2'd2
  } estado_t;

  // Flag register layout: {negativo, zero, cout, overflow}
  localparam int FLAG_NEG  = 3;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_COUT = 1;
  localparam int FLAG_OVF  = 0;

  function automatic logic es_reservado(input logic [3:0] op);
    return op >= OP_RESERVED_MIN;
  endfunction

  // Ops whose carry-out means the accumulated result left the unsigned range.
  function automatic logic satura_op(input logic [3:0] op);
    return (op == OP_SUMA) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/alu_secuenciador_banco.sv
// -----------------------------------------------------------------------------
// banco_registros
// NREG x N general register file for the ALU sequencer.
//   clk, rst        : clock, synchronous active-high clear of every register
//   we/waddr/wdata  : single synchronous write port
//   addr_a/data_a   : combinational read (source A, used when a command is accepted)
//   addr_b/data_b   : combinational read (source B, used while executing)
//   rd_addr/rd_data : combinational read for the front-end
// A write is visible on the read ports from the cycle after it occurs.
// -----------------------------------------------------------------------------
module banco_registros #(
  parameter int N    = 3,
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] addr_a,
  output logic [N-1:0]  data_a,
  input  logic [AW-1:0] addr_b,
  output logic [N-1:0]  data_b,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0] regs [NREG];

  // NOTE: flop state is written with non-blocking assignments so every reader
  // sees the pre-edge value regardless of process evaluation order.
  // NOTE: this array is a handful of flops, not a RAM macro, so clearing it on
  // reset is cheap and gives a defined power-up state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign data_a  = regs[addr_a];
  assign data_b  = regs[addr_b];
  assign rd_data = regs[rd_addr];

endmodule

// File: rtl/alu_secuenciador.sv
// -----------------------------------------------------------------------------
// alu_secuenciador
// Command sequencer driving an external combinational ALU from a register file.
// A command (op, dst, srca, srcb, flagin, rep) is accepted on cmd_valid &
// cmd_ready. The ALU op runs rep+1 times, each result fed back as operand A;
// the final value goes to reg[dst], the flag register is updated and done
// pulses for one cycle. Ops >= 10 are reserved: done+err, nothing written.
//
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_*     : command handshake and fields
//   wr_en/wr_addr/wr_data          : direct preload (IDLE only, beats commands)
//   rd_addr/rd_data                : combinational register read
//   alu_A/alu_B/alu_flagin/alu_select : ALU drive (select=0 outside execution,
//                                    operands hold their last driven values)
//   alu_resultado, alu_negativo, alu_zero, alu_cout, alu_overflow : ALU returns
//   done, err                      : completion pulse, reserved-op indication
//   flags                          : {negativo, zero, cout, overflow}
//   busy                           : sequencer not idle
//
// Build option: define ALU_SECUENCIADOR_SAT_EN to saturate add/inc results at
// all-ones once a carry-out occurs; otherwise results wrap modulo 2^N.
// -----------------------------------------------------------------------------
module alu_secuenciador
  import alu_secuenciador_pkg::*;
#(
  parameter  int N    = 3,
  parameter  int NREG = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srca,
  input  logic [AW-1:0] cmd_srcb,
  input  logic          cmd_flagin,
  input  logic [N-1:0]  cmd_rep,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  output logic [N-1:0]  alu_A,
  output logic [N-1:0]  alu_B,
  output logic          alu_flagin,
  output logic [3:0]    alu_select,
  input  logic [N-1:0]  alu_resultado,
  input  logic          alu_negativo,
  input  logic          alu_zero,
  input  logic          alu_cout,
  input  logic          alu_overflow,
  output logic          done,
  output logic          err,
  output logic [3:0]    flags,
  output logic          busy
);

  estado_t state, state_next;

  // Latched command
  logic [3:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] srcb_q;
  logic          flagin_q;
  logic          err_q;

  // Iteration state
  logic [N-1:0]  counter;
  logic [N-1:0]  temp;
  logic          first_q;
  logic          cout_acc;
  logic          ovf_acc;
  logic          neg_last;
  logic          zero_last;
  logic [3:0]    flags_q;

  // Last values driven onto the ALU, replayed while not executing
  logic [N-1:0]  a_hold;
  logic [N-1:0]  b_hold;
  logic          fi_hold;

  // Register file hookup
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [N-1:0]  rf_wdata;
  logic [N-1:0]  srca_data;
  logic [N-1:0]  srcb_data;

  logic          accept;

`ifdef ALU_SECUENCIADOR_SAT_EN
  logic          sat_q;
`endif

  banco_registros #(
    .N    (N),
    .NREG (NREG),
    .AW   (AW)
  ) u_banco (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .addr_a  (cmd_srca),
    .data_a  (srca_data),
    .addr_b  (srcb_q),
    .data_b  (srcb_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    alu_select = '0;
    alu_A      = a_hold;
    alu_B      = b_hold;
    alu_flagin = fi_hold;
    rf_we      = 1'b0;
    rf_waddr   = wr_addr;
    rf_wdata   = wr_data;

    case (state)
      IDLE: begin
        // Preload wins over a pending command in the same cycle.
        cmd_ready = ~wr_en;
        rf_we     = wr_en;
        if (cmd_valid && !wr_en) begin
          state_next = es_reservado(cmd_op) ? ESCRIBE : EJECUTA;
        end
      end

      EJECUTA: begin
        alu_select = op_q;
        alu_A      = temp;
        alu_B      = srcb_data;
        // After the first pass flagin is forced high so unary ops
        // (inc/dec/not) keep working on the fed-back A operand.
        alu_flagin = first_q ? flagin_q : 1'b1;
        if (counter == '0) state_next = ESCRIBE;
      end

      ESCRIBE: begin
        done       = 1'b1;
        err        = err_q;
        rf_we      = ~err_q;
        rf_waddr   = dst_q;
        rf_wdata   = temp;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;
  assign busy   = (state != IDLE);
  assign flags  = flags_q;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      dst_q     <= '0;
      srcb_q    <= '0;
      flagin_q  <= 1'b0;
      err_q     <= 1'b0;
      counter   <= '0;
      temp      <= '0;
      first_q   <= 1'b0;
      cout_acc  <= 1'b0;
      ovf_acc   <= 1'b0;
      neg_last  <= 1'b0;
      zero_last <= 1'b0;
      flags_q   <= '0;
      a_hold    <= '0;
      b_hold    <= '0;
      fi_hold   <= 1'b0;
`ifdef ALU_SECUENCIADOR_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= cmd_op;
            dst_q    <= cmd_dst;
            srcb_q   <= cmd_srcb;
            flagin_q <= cmd_flagin;
            err_q    <= es_reservado(cmd_op);
            counter  <= cmd_rep;
            temp     <= srca_data;
            first_q  <= 1'b1;
            cout_acc <= 1'b0;
            ovf_acc  <= 1'b0;
`ifdef ALU_SECUENCIADOR_SAT_EN
            sat_q    <= 1'b0;
`endif
          end
        end

        EJECUTA: begin
          first_q   <= 1'b0;
          a_hold    <= alu_A;
          b_hold    <= alu_B;
          fi_hold   <= alu_flagin;
          // Carry/overflow are sticky over the whole run; sign/zero describe
          // only the final pass.
          cout_acc  <= cout_acc | alu_cout;
          ovf_acc   <= ovf_acc | alu_overflow;
          neg_last  <= alu_negativo;
          zero_last <= alu_zero;
`ifdef ALU_SECUENCIADOR_SAT_EN
          // Once saturated, the all-ones value is frozen for remaining passes.
          if (!sat_q) begin
            if (satura_op(op_q) && alu_cout) begin
              temp  <= '1;
              sat_q <= 1'b1;
            end else begin
              temp  <= alu_resultado;
            end
          end
`else
          temp <= alu_resultado;
`endif
          if (counter != '0) counter <= counter - 1'b1;
        end

        ESCRIBE: begin
          if (!err_q) begin
            flags_q[FLAG_NEG]  <= neg_last;
            flags_q[FLAG_ZERO] <= zero_last;
            flags_q[FLAG_COUT] <= cout_acc;
            flags_q[FLAG_OVF]  <= ovf_acc;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_secuenciador.sv
// -----------------------------------------------------------------------------
// tb_alu_secuenciador
// Bench for alu_secuenciador. Provides a stand-in combinational ALU, a
// command-level model (whole command outcome computed with a plain loop at
// acceptance), a per-cycle compare process and directed scenarios with
// hand-computed literal expectations.
//
// Stand-in ALU (operand X = flagin ? A : B for unary ops):
//   0 add A+B, 1 sub A-B, 2 inc X, 3 dec X, 4 and, 5 or, 6 not X, 7 xor,
//   8 shl X, 9 shr X. cout = carry/borrow/shifted-out bit; overflow = the
//   unsigned-range overflow of add/sub/inc/dec; negativo = MSB; zero = (r==0).
// -----------------------------------------------------------------------------
module tb_alu_secuenciador;

  localparam int N    = 3;
  localparam int NREG = 4;
  localparam int AW   = 2;
  localparam logic [N-1:0] UNO = 1;

`ifdef ALU_SECUENCIADOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_srca;
  logic [AW-1:0] cmd_srcb;
  logic          cmd_flagin;
  logic [N-1:0]  cmd_rep;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic [N-1:0]  alu_A;
  logic [N-1:0]  alu_B;
  logic          alu_flagin;
  logic [3:0]    alu_select;
  logic [N-1:0]  alu_resultado;
  logic          alu_negativo;
  logic          alu_zero;
  logic          alu_cout;
  logic          alu_overflow;
  logic          done;
  logic          err;
  logic [3:0]    flags;
  logic          busy;

  alu_secuenciador dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_dst       (cmd_dst),
    .cmd_srca      (cmd_srca),
    .cmd_srcb      (cmd_srcb),
    .cmd_flagin    (cmd_flagin),
    .cmd_rep       (cmd_rep),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .alu_A         (alu_A),
    .alu_B         (alu_B),
    .alu_flagin    (alu_flagin),
    .alu_select    (alu_select),
    .alu_resultado (alu_resultado),
    .alu_negativo  (alu_negativo),
    .alu_zero      (alu_zero),
    .alu_cout      (alu_cout),
    .alu_overflow  (alu_overflow),
    .done          (done),
    .err           (err),
    .flags         (flags),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stand-in ALU
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [N-1:0] r;
    logic         c;
    logic         v;
  } alu_out_t;

  function automatic alu_out_t alu_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [3:0] op, input logic fi);
    alu_out_t     o;
    logic [N:0]   s;
    logic [N-1:0] x;
    x = fi ? a : b;
    o = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b};   o.r = s[N-1:0]; o.c = s[N]; o.v = s[N]; end
      4'd1: begin o.r = a - b;   o.c = (a < b);    o.v = o.c; end
      4'd2: begin s = {1'b0, x} + {1'b0, UNO}; o.r = s[N-1:0]; o.c = s[N]; o.v = s[N]; end
      4'd3: begin o.r = x - UNO; o.c = (x == '0); o.v = o.c; end
      4'd4: o.r = a & b;
      4'd5: o.r = a | b;
      4'd6: o.r = ~x;
      4'd7: o.r = a ^ b;
      4'd8: begin o.r = x << 1; o.c = x[N-1]; end
      4'd9: begin o.r = x >> 1; o.c = x[0];   end
      default: ;
    endcase
    return o;
  endfunction

  alu_out_t ao;
  always_comb begin
    ao            = alu_ref(alu_A, alu_B, alu_select, alu_flagin);
    alu_resultado = ao.r;
    alu_cout      = ao.c;
    alu_overflow  = ao.v;
    alu_negativo  = ao.r[N-1];
    alu_zero      = (ao.r == '0);
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Command-level model. Cycle k is the interval following the k-th posedge.
  // ---------------------------------------------------------------------------
  logic [N-1:0]  m_reg [NREG];
  logic [3:0]    m_flags = '0;
  bit            pend = 1'b0;
  int            ciclo = 0;
  int            busy_from = 0;
  int            done_at = 0;
  logic          m_res;
  logic [3:0]    m_op;
  logic [AW-1:0] m_dst;
  logic [N-1:0]  m_val;
  logic [N-1:0]  m_b;
  logic [3:0]    m_newflags;
  logic [N-1:0]  exp_a  [2**N];
  logic          exp_fi [2**N];

  task automatic run_model();
    logic [N-1:0] t;
    alu_out_t     o;
    logic         cacc, vacc, nl, zl;
    bit           sat;
    int           reps;
    cacc = 1'b0; vacc = 1'b0; nl = 1'b0; zl = 1'b0; sat = 1'b0;
    m_op      = cmd_op;
    m_dst     = cmd_dst;
    m_res     = (cmd_op >= 4'd10);
    pend      = 1'b1;
    busy_from = ciclo + 1;
    m_b       = m_reg[cmd_srcb];
    t         = m_reg[cmd_srca];
    if (m_res) begin
      done_at = ciclo + 1;
    end else begin
      reps    = int'(cmd_rep) + 1;
      done_at = ciclo + 1 + reps;
      for (int i = 0; i < reps; i++) begin
        exp_fi[i] = (i == 0) ? cmd_flagin : 1'b1;
        exp_a[i]  = t;
        o    = alu_ref(t, m_b, cmd_op, exp_fi[i]);
        cacc = cacc | o.c;
        vacc = vacc | o.v;
        nl   = o.r[N-1];
        zl   = (o.r == '0);
        if (SAT) begin
          if (!sat) begin
            if ((cmd_op == 4'd0 || cmd_op == 4'd2) && o.c) begin
              sat = 1'b1;
              t   = '1;
            end else begin
              t = o.r;
            end
          end
        end else begin
          t = o.r;
        end
      end
      m_val      = t;
      m_newflags = {nl, zl, cacc, vacc};
    end
  endtask

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_reg[i] = '0;
      m_flags = '0;
      pend    = 1'b0;
    end else if (pend && ciclo == done_at) begin
      if (!m_res) begin
        m_reg[m_dst] = m_val;
        m_flags      = m_newflags;
      end
      pend = 1'b0;
    end else if (!pend && wr_en) begin
      m_reg[wr_addr] = wr_data;
    end else if (!pend && cmd_valid) begin
      run_model();
    end
    ciclo++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic compare();
    bit eb, ed, ex;
    int i;
    eb = pend && ciclo >= busy_from && ciclo <= done_at;
    ed = pend && ciclo == done_at;
    ex = eb && !m_res && ciclo < done_at;
    check("busy",       32'(busy),       32'(eb));
    check("cmd_ready",  32'(cmd_ready),  32'(!eb && !wr_en));
    check("done",       32'(done),       32'(ed));
    check("err",        32'(err),        32'(ed && m_res));
    check("flags",      32'(flags),      32'(m_flags));
    check("rd_data",    32'(rd_data),    32'(m_reg[rd_addr]));
    check("alu_select", 32'(alu_select), ex ? 32'(m_op) : 32'd0);
    if (ex) begin
      i = ciclo - busy_from;
      check("alu_A",      32'(alu_A),      32'(exp_a[i]));
      check("alu_B",      32'(alu_B),      32'(m_b));
      check("alu_flagin", 32'(alu_flagin), 32'(exp_fi[i]));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) compare();
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [N-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [N-1:0] exp);
    rd_addr = a;
    tick();
    check(name, 32'(rd_data), 32'(exp));
  endtask

  // Presents a command, waits (bounded) for acceptance, then counts cycles
  // until done. Returns in the done cycle with lat = done cycle - accept cycle.
  task automatic send_cmd(input logic [3:0] op, input logic [AW-1:0] dst,
                          input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic fi, input logic [N-1:0] rep,
                          output int lat, output logic err_at_done);
    int w;
    cmd_op     = op;
    cmd_dst    = dst;
    cmd_srca   = a;
    cmd_srcb   = b;
    cmd_flagin = fi;
    cmd_rep    = rep;
    cmd_valid  = 1'b1;
    #1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      tick();
      #1;
      w++;
    end
    if (w >= 20) check("accept_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    err_at_done = err;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int   lat;
    logic e;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srca = '0;
    cmd_srcb = '0; cmd_flagin = 1'b0; cmd_rep = '0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    // 1: reset state
    check("t1_ready", 32'(cmd_ready), 32'd1);
    check("t1_busy",  32'(busy),      32'd0);
    check("t1_done",  32'(done),      32'd0);
    check("t1_flags", 32'(flags),     32'd0);
    for (int i = 0; i < NREG; i++) read_chk("t1_rd", AW'(i), 3'd0);

    // 2: 3 + 5 wraps to 0 with carry
    preload(2'd0, 3'd3);
    preload(2'd1, 3'd5);
    send_cmd(4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 3'd0, lat, e);
    check("t2_lat", 32'(lat), 32'd2);
    read_chk("t2_r2", 2'd2, SAT ? 3'd7 : 3'd0);
    check("t2_flags", 32'(flags), 32'b0111);

    // 3: inc x4 from 5 -> 6,7,0,1
    preload(2'd0, 3'd5);
    send_cmd(4'd2, 2'd3, 2'd0, 2'd0, 1'b1, 3'd3, lat, e);
    check("t3_lat", 32'(lat), 32'd5);
    read_chk("t3_r3", 2'd3, SAT ? 3'd7 : 3'd1);
    check("t3_flags", 32'(flags), SAT ? 32'b0111 : 32'b0011);

    // 4: reserved op
    send_cmd(4'd12, 2'd1, 2'd0, 2'd0, 1'b0, 3'd0, lat, e);
    check("t4_lat", 32'(lat), 32'd1);
    check("t4_err", 32'(e),   32'd1);
    read_chk("t4_r1", 2'd1, 3'd5);
    check("t4_flags", 32'(flags), SAT ? 32'b0111 : 32'b0011);

    // 5: preload beats a pending command; command sees the new R0
    cmd_op = 4'd0; cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd0;
    cmd_flagin = 1'b0; cmd_rep = 3'd0; cmd_valid = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 3'd1;
    #1;
    check("t5_ready0", 32'(cmd_ready), 32'd0);
    tick();
    wr_data = 3'd2;
    #1;
    check("t5_ready1", 32'(cmd_ready), 32'd0);
    tick();
    wr_en = 1'b0;
    send_cmd(4'd0, 2'd2, 2'd0, 2'd0, 1'b0, 3'd0, lat, e);
    check("t5_lat", 32'(lat), 32'd2);
    read_chk("t5_r2", 2'd2, 3'd4);
    check("t5_flags", 32'(flags), 32'b1000);

    // 6: reset in the middle of a run
    cmd_op = 4'd8; cmd_dst = 2'd3; cmd_srca = 2'd0; cmd_srcb = 2'd0;
    cmd_flagin = 1'b1; cmd_rep = 3'd5; cmd_valid = 1'b1;
    #1;
    check("t6_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("t6_busy", 32'(busy), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    read_chk("t6_r3", 2'd3, 3'd0);
    check("t6_flags", 32'(flags), 32'd0);

    // 7: counter wrap: rep=7 gives 8 decrements, 2 - 8 wraps back to 2
    preload(2'd1, 3'd2);
    send_cmd(4'd3, 2'd0, 2'd1, 2'd1, 1'b1, 3'd7, lat, e);
    check("t7_lat", 32'(lat), 32'd9);
    read_chk("t7_r0", 2'd0, 3'd2);
    check("t7_flags", 32'(flags), 32'b0011);

    // 8: AND, then NOT where pass 1 uses B and pass 2 uses fed-back A
    preload(2'd2, 3'd6);
    preload(2'd3, 3'd3);
    send_cmd(4'd4, 2'd1, 2'd2, 2'd3, 1'b0, 3'd0, lat, e);
    check("t8_lat", 32'(lat), 32'd2);
    read_chk("t8_r1", 2'd1, 3'd2);
    send_cmd(4'd6, 2'd0, 2'd2, 2'd3, 1'b0, 3'd1, lat, e);
    check("t8_not_lat", 32'(lat), 32'd3);
    read_chk("t8_r0", 2'd0, 3'd3);
    check("t8_flags", 32'(flags), 32'b0000);

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
